alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Instruction-issue and writeback controller that drives the ALU from the opposite side of its interface.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 16x16 register file.
- Drives the ALU opcode, operand, shift and execute inputs, then captures the ALU result and flags and writes them back.
- Sits between instruction fetch and the combinational ALU; it is the initiator of every ALU operation.

Parameters:
- DATA_W, 16, register and ALU datapath width.
- NREGS, 16, register file depth; addressed by 4-bit fields.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- instr_valid  in  1  instruction word present.
- instr  in  16  instruction word; fields are [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/shamt.
- instr_ready  out  1  controller can accept an instruction.
- load_en  in  1  direct register-file write, for init/test.
- load_addr  in  4  register written by load_en.
- load_data  in  DATA_W  value written by load_en.
- dbg_addr  in  4  combinational register readback address.
- dbg_data  out  DATA_W  contents of register[dbg_addr].
- alu_opcode  out  4  ALU operation select.
- alu_r2  out  DATA_W  ALU operand A.
- alu_r3  out  DATA_W  ALU operand B.
- alu_shift  out  4  ALU shift amount.
- alu_execute  out  1  ALU enable.
- alu_r1  in  DATA_W  ALU result.
- alu_flags  in  4  ALU flags.
- wb_valid  out  1  one-cycle pulse when rd is written.
- wb_addr  out  4  register written.
- wb_data  out  DATA_W  value written.
- flags_q  out  4  last captured ALU flags.
- illegal_q  out  1  last instruction had an illegal opcode.
- busy  out  1  state is not IDLE.

Behaviour:
- Opcode map: 0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 RSH, 7 LSH, 8 ROR, 9 CMP. Opcodes 10-15 are illegal.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = ~load_en.
  - An accept (instr_valid & instr_ready) at edge E latches op and rd.
  - At E, alu_r2 <= reg[rs].
  - At E, alu_r3 <= reg[rt] for opcodes 0-5 and 9; otherwise 0.
  - At E, alu_shift <= rt for opcodes 6-8; otherwise 0.
  - Operands are taken from the register file state before edge E.
  - Next state is EXEC.
  - clears illegal_q at E.
- EXEC (one cycle):
  - alu_execute = 1 for legal opcodes; 0 for illegal.
  - alu_opcode = op for opcodes 0-8. CMP drives opcode 1 (SUB).
  - At edge E+1: capture alu_r1 and alu_flags; next state is WB.
- WB (one cycle):
  - Opcodes 0-8: wb_valid = 1, wb_addr = rd, wb_data = captured result; reg[rd] is written at edge E+2.
  - All legal opcodes, including CMP: flags_q <= captured flags at edge E+2.
  - CMP: no register write; wb_valid = 0.
  - Illegal: no write; flags_q unchanged; illegal_q <= 1 at E+2.
  - Next state is IDLE.
- Timing and throughput:
  - One instruction per 3 cycles.
  - instr_ready is low in EXEC and WB.
  - The earliest next accept is edge E+3, which sees the value written at E+2. There is no RAW hazard.
- Register-file load:
  - load_en is honoured only in IDLE and is ignored in EXEC/WB.
  - While load_en is high, instr_ready is forced to 0, so a load and an accept never occur in the same cycle.
- alu_* outputs hold their last values outside EXEC; only alu_execute deasserts.
- dbg_data is combinational from the register file.
- Reset (asserted at any time, including mid-instruction):
  - state <= IDLE.
  - All registers, alu_* outputs, flags_q, illegal_q, wb_* cleared to 0.
  - Any in-flight instruction is discarded with no writeback.
  - After deassert, instr_ready = 1 in the first cycle.
- Arithmetic: all widths are DATA_W; result truncation and overflow are entirely the ALU's; this block does no arithmetic.

Test Plan:
- Load R2 = 0x0005 and R3 = 0x0003, issue 0x0123 (ADD R1,R2,R3) -> alu_execute high 1 cycle with alu_r2 = 5, alu_r3 = 3; wb_valid 2 cycles after accept with wb_addr = 1, wb_data = 0x0008; dbg R1 = 0x0008.
- Issue 0x7524 (LSH R5,R2,#4) -> alu_shift = 4, alu_r3 = 0, R5 = 0x0050.
- Issue 0x9023 (CMP R2,R3) -> alu_opcode = 1, no wb_valid, R0 stays 0, flags_q = ALU flags of 5-3.
- Issue 0xF123 -> alu_execute never high, no wb_valid, illegal_q = 1. A following 0x0123 clears illegal_q at its accept.
- Hold instr_valid with 0x0623 then 0x0716 (R7 = R1+R6, RAW on R6) -> second accept exactly 3 cycles after the first; instr_ready low 2 cycles; R7 = R1 + 0x0008.
- Assert rst during EXEC of 0x0123 -> no wb_valid, all registers 0, instr_ready = 1 after release; load_en during IDLE holds instr_ready low.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the fetch, register-load, debug, ALU-drive and writeback signals
// seen by alu_issue_ctrl. The controller takes the slave view.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic              load_en;
  logic [3:0]        load_addr;
  logic [DATA_W-1:0] load_data;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [3:0]        alu_opcode;
  logic [DATA_W-1:0] alu_r2;
  logic [DATA_W-1:0] alu_r3;
  logic [3:0]        alu_shift;
  logic              alu_execute;
  logic [DATA_W-1:0] alu_r1;
  logic [3:0]        alu_flags;
  logic              wb_valid;
  logic [3:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        flags_q;
  logic              illegal_q;
  logic              busy;

  modport slave (
    input  instr_valid, instr, load_en, load_addr, load_data, dbg_addr,
           alu_r1, alu_flags,
    output instr_ready, dbg_data, alu_opcode, alu_r2, alu_r3, alu_shift,
           alu_execute, wb_valid, wb_addr, wb_data, flags_q, illegal_q, busy
  );

  modport master (
    output instr_valid, instr, load_en, load_addr, load_data, dbg_addr,
           alu_r1, alu_flags,
    input  instr_ready, dbg_data, alu_opcode, alu_r2, alu_r3, alu_shift,
           alu_execute, wb_valid, wb_addr, wb_data, flags_q, illegal_q, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a combinational ALU: accept an instruction,
// drive operands for one EXEC cycle, then write result and flags back.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus
);

  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_RSH = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [3:0]        op_q, rd_q;
  logic [DATA_W-1:0] alu_r2_q, alu_r3_q, res_q;
  logic [3:0]        alu_opcode_q, alu_shift_q;
  logic [3:0]        cap_flags_q, flags_q;
  logic              illegal_q;

  logic [3:0] in_op, in_rd, in_rs, in_rt;
  logic       accept, do_load;
  logic       op_legal, op_writes;
  logic       in_uses_rt, in_is_shift;

  assign in_op = bus.instr[15:12];
  assign in_rd = bus.instr[11:8];
  assign in_rs = bus.instr[7:4];
  assign in_rt = bus.instr[3:0];

  assign op_legal    = (op_q <= OP_CMP);
  assign op_writes   = (op_q <= OP_ROR);
  assign in_uses_rt  = (in_op <= OP_XOR) || (in_op == OP_CMP);
  assign in_is_shift = (in_op >= OP_RSH) && (in_op <= OP_ROR);

  // FSM next state and control outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d         = state_q;
    accept          = 1'b0;
    do_load         = 1'b0;
    bus.instr_ready = 1'b0;
    bus.alu_execute = 1'b0;
    bus.wb_valid    = 1'b0;
    bus.busy        = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        bus.busy        = 1'b0;
        bus.instr_ready = ~bus.load_en;
        do_load         = bus.load_en;
        accept          = bus.instr_valid & ~bus.load_en;
        if (accept) state_d = S_EXEC;
      end
      S_EXEC: begin
        bus.alu_execute = op_legal;
        state_d         = S_WB;
      end
      S_WB: begin
        bus.wb_valid = op_writes;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath: operand latch at accept, ALU capture in EXEC, writeback in WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is a flop array rather than a RAM precisely
      // because it must clear on reset; a RAM macro could not be reset here.
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      alu_r2_q     <= '0;
      alu_r3_q     <= '0;
      alu_shift_q  <= '0;
      alu_opcode_q <= '0;
      res_q        <= '0;
      cap_flags_q  <= '0;
      flags_q      <= '0;
      illegal_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q         <= in_op;
        rd_q         <= in_rd;
        alu_r2_q     <= rf_q[in_rs];
        alu_r3_q     <= in_uses_rt  ? rf_q[in_rt] : '0;
        alu_shift_q  <= in_is_shift ? in_rt : '0;
        alu_opcode_q <= (in_op == OP_CMP) ? OP_SUB : in_op;
        illegal_q    <= 1'b0;
      end
      if (do_load) rf_q[bus.load_addr] <= bus.load_data;
      if (state_q == S_EXEC) begin
        res_q       <= bus.alu_r1;
        cap_flags_q <= bus.alu_flags;
      end
      // The WB write lands one edge before the earliest next accept, so the
      // following instruction always reads the fresh value.
      if (state_q == S_WB) begin
        if (op_writes) rf_q[rd_q] <= res_q;
        if (op_legal)  flags_q    <= cap_flags_q;
        else           illegal_q  <= 1'b1;
      end
    end
  end

  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_r2     = alu_r2_q;
  assign bus.alu_r3     = alu_r3_q;
  assign bus.alu_shift  = alu_shift_q;
  assign bus.wb_addr    = rd_q;
  assign bus.wb_data    = res_q;
  assign bus.flags_q    = flags_q;
  assign bus.illegal_q  = illegal_q;
  assign bus.dbg_data   = rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU on the far
// side of the interface; flags are {zero, negative, carry, 0}.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_issue_ctrl_if #(.DATA_W(16)) bus ();

  alu_issue_ctrl #(.DATA_W(16), .NREGS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU responding to the controller's drive.
  always_comb begin
    logic [16:0] w;
    logic [31:0] p;
    w = '0;
    p = bus.alu_r2 * bus.alu_r3;
    case (bus.alu_opcode)
      4'd0: w = {1'b0, bus.alu_r2} + {1'b0, bus.alu_r3};
      4'd1: w = {1'b0, bus.alu_r2} - {1'b0, bus.alu_r3};
      4'd2: w = {1'b0, p[15:0]};
      4'd3: w = {1'b0, bus.alu_r2 | bus.alu_r3};
      4'd4: w = {1'b0, bus.alu_r2 & bus.alu_r3};
      4'd5: w = {1'b0, bus.alu_r2 ^ bus.alu_r3};
      4'd6: w = {1'b0, bus.alu_r2 >> bus.alu_shift};
      4'd7: w = {1'b0, bus.alu_r2 << bus.alu_shift};
      4'd8: w = {1'b0, (bus.alu_r2 >> bus.alu_shift) | (bus.alu_r2 << (5'd16 - {1'b0, bus.alu_shift}))};
      default: w = '0;
    endcase
    bus.alu_r1    = w[15:0];
    bus.alu_flags = {(w[15:0] == 16'h0), w[15], w[16], 1'b0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic load_reg(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  // Present an instruction for one cycle; returns at the EXEC-cycle negedge.
  task automatic start(input logic [15:0] w);
    @(negedge clk);
    bus.instr = w; bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.instr_ready); end checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end checks++;
    if (bus.flags_q !== 4'h0) begin errors++; $display("FAIL rst_flags got %h exp 0", bus.flags_q); end checks++;
    if (bus.illegal_q !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", bus.illegal_q); end checks++;
    if (bus.alu_execute !== 1'b0) begin errors++; $display("FAIL rst_exec got %b exp 0", bus.alu_execute); end checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wbv got %b exp 0", bus.wb_valid); end checks++;
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = i[3:0]; #1;
      if (bus.dbg_data !== 16'h0) begin errors++; $display("FAIL rst_reg%0d got %h exp 0", i, bus.dbg_data); end checks++;
    end
  endtask

  task automatic test_add();
    load_reg(4'd2, 16'h0005);
    load_reg(4'd3, 16'h0003);
    start(16'h0123);
    if (bus.alu_execute !== 1'b1) begin errors++; $display("FAIL add_exec got %b exp 1", bus.alu_execute); end checks++;
    if (bus.alu_r2 !== 16'h0005) begin errors++; $display("FAIL add_r2 got %h exp 0005", bus.alu_r2); end checks++;
    if (bus.alu_r3 !== 16'h0003) begin errors++; $display("FAIL add_r3 got %h exp 0003", bus.alu_r3); end checks++;
    if (bus.alu_opcode !== 4'd0) begin errors++; $display("FAIL add_opc got %h exp 0", bus.alu_opcode); end checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL add_wbv_exec got %b exp 0", bus.wb_valid); end checks++;
    step();
    if (bus.alu_execute !== 1'b0) begin errors++; $display("FAIL add_exec_wb got %b exp 0", bus.alu_execute); end checks++;
    if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL add_wbv got %b exp 1", bus.wb_valid); end checks++;
    if (bus.wb_addr !== 4'd1) begin errors++; $display("FAIL add_wba got %h exp 1", bus.wb_addr); end checks++;
    if (bus.wb_data !== 16'h0008) begin errors++; $display("FAIL add_wbd got %h exp 0008", bus.wb_data); end checks++;
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL add_wbv_idle got %b exp 0", bus.wb_valid); end checks++;
    bus.dbg_addr = 4'd1; #1;
    if (bus.dbg_data !== 16'h0008) begin errors++; $display("FAIL add_r1 got %h exp 0008", bus.dbg_data); end checks++;
  endtask

  task automatic test_lsh();
    start(16'h7524);
    if (bus.alu_shift !== 4'd4) begin errors++; $display("FAIL lsh_shift got %h exp 4", bus.alu_shift); end checks++;
    if (bus.alu_r3 !== 16'h0000) begin errors++; $display("FAIL lsh_r3 got %h exp 0000", bus.alu_r3); end checks++;
    if (bus.alu_r2 !== 16'h0005) begin errors++; $display("FAIL lsh_r2 got %h exp 0005", bus.alu_r2); end checks++;
    if (bus.alu_opcode !== 4'd7) begin errors++; $display("FAIL lsh_opc got %h exp 7", bus.alu_opcode); end checks++;
    step();
    if (bus.wb_addr !== 4'd5) begin errors++; $display("FAIL lsh_wba got %h exp 5", bus.wb_addr); end checks++;
    step();
    bus.dbg_addr = 4'd5; #1;
    if (bus.dbg_data !== 16'h0050) begin errors++; $display("FAIL lsh_r5 got %h exp 0050", bus.dbg_data); end checks++;
  endtask

  task automatic test_cmp();
    start(16'h9032);
    if (bus.alu_opcode !== 4'd1) begin errors++; $display("FAIL cmp_opc got %h exp 1", bus.alu_opcode); end checks++;
    if (bus.alu_execute !== 1'b1) begin errors++; $display("FAIL cmp_exec got %b exp 1", bus.alu_execute); end checks++;
    if (bus.alu_r3 !== 16'h0005) begin errors++; $display("FAIL cmp_r3 got %h exp 0005", bus.alu_r3); end checks++;
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL cmp_wbv got %b exp 0", bus.wb_valid); end checks++;
    step();
    if (bus.flags_q !== 4'b0110) begin errors++; $display("FAIL cmp_flags_neg got %b exp 0110", bus.flags_q); end checks++;
    bus.dbg_addr = 4'd0; #1;
    if (bus.dbg_data !== 16'h0000) begin errors++; $display("FAIL cmp_r0 got %h exp 0000", bus.dbg_data); end checks++;
    start(16'h9023);
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL cmp2_wbv got %b exp 0", bus.wb_valid); end checks++;
    step();
    if (bus.flags_q !== 4'b0000) begin errors++; $display("FAIL cmp_flags_pos got %b exp 0000", bus.flags_q); end checks++;
    bus.dbg_addr = 4'd0; #1;
    if (bus.dbg_data !== 16'h0000) begin errors++; $display("FAIL cmp2_r0 got %h exp 0000", bus.dbg_data); end checks++;
    start(16'h9032);
    step();
    step();
    if (bus.flags_q !== 4'b0110) begin errors++; $display("FAIL cmp3_flags got %b exp 0110", bus.flags_q); end checks++;
  endtask

  task automatic test_illegal();
    start(16'hF123);
    if (bus.alu_execute !== 1'b0) begin errors++; $display("FAIL ill_exec got %b exp 0", bus.alu_execute); end checks++;
    step();
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL ill_wbv got %b exp 0", bus.wb_valid); end checks++;
    if (bus.alu_execute !== 1'b0) begin errors++; $display("FAIL ill_exec_wb got %b exp 0", bus.alu_execute); end checks++;
    step();
    if (bus.illegal_q !== 1'b1) begin errors++; $display("FAIL ill_flag got %b exp 1", bus.illegal_q); end checks++;
    if (bus.flags_q !== 4'b0110) begin errors++; $display("FAIL ill_flags_hold got %b exp 0110", bus.flags_q); end checks++;
    bus.dbg_addr = 4'd1; #1;
    if (bus.dbg_data !== 16'h0008) begin errors++; $display("FAIL ill_r1 got %h exp 0008", bus.dbg_data); end checks++;
    start(16'h0123);
    if (bus.illegal_q !== 1'b0) begin errors++; $display("FAIL ill_clear got %b exp 0", bus.illegal_q); end checks++;
    step();
    step();
    if (bus.flags_q !== 4'b0000) begin errors++; $display("FAIL ill_next_flags got %b exp 0000", bus.flags_q); end checks++;
  endtask

  task automatic test_back_to_back();
    int  first = -1;
    int  second = -1;
    int  low = 0;
    bit  done = 1'b0;
    @(negedge clk);
    bus.instr = 16'h0623; bus.instr_valid = 1'b1;
    for (int c = 0; c < 10 && !done; c++) begin
      if (bus.instr_ready) begin
        if (first < 0) first = c;
        else begin second = c; done = 1'b1; end
      end else low++;
      @(posedge clk); #1;
      if (first == c && !done) bus.instr = 16'h0716;
      if (done) bus.instr_valid = 1'b0;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    if (second - first !== 3) begin errors++; $display("FAIL b2b_gap got %0d exp 3", second - first); end checks++;
    if (low !== 2) begin errors++; $display("FAIL b2b_ready_low got %0d exp 2", low); end checks++;
    if (bus.alu_r3 !== 16'h0008) begin errors++; $display("FAIL b2b_raw_r3 got %h exp 0008", bus.alu_r3); end checks++;
    step();
    if (bus.wb_addr !== 4'd7 || bus.wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb got %h/%b exp 7/1", bus.wb_addr, bus.wb_valid); end checks++;
    step();
    bus.dbg_addr = 4'd7; #1;
    if (bus.dbg_data !== 16'h0010) begin errors++; $display("FAIL b2b_r7 got %h exp 0010", bus.dbg_data); end checks++;
    bus.dbg_addr = 4'd6; #1;
    if (bus.dbg_data !== 16'h0008) begin errors++; $display("FAIL b2b_r6 got %h exp 0008", bus.dbg_data); end checks++;
  endtask

  task automatic test_load();
    @(negedge clk);
    bus.load_en = 1'b1; bus.load_addr = 4'd4; bus.load_data = 16'hAAAA;
    bus.instr = 16'h0123; bus.instr_valid = 1'b1;
    #1;
    if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL load_ready got %b exp 0", bus.instr_ready); end checks++;
    @(negedge clk);
    bus.load_en = 1'b0; bus.instr_valid = 1'b0;
    #1;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL load_noaccept got %b exp 0", bus.busy); end checks++;
    bus.dbg_addr = 4'd4; #1;
    if (bus.dbg_data !== 16'hAAAA) begin errors++; $display("FAIL load_r4 got %h exp aaaa", bus.dbg_data); end checks++;
    start(16'h0123);
    bus.load_en = 1'b1; bus.load_addr = 4'd9; bus.load_data = 16'h5555;
    step();
    step();
    bus.load_en = 1'b0;
    bus.dbg_addr = 4'd9; #1;
    if (bus.dbg_data !== 16'h0000) begin errors++; $display("FAIL load_busy_ignored got %h exp 0000", bus.dbg_data); end checks++;
  endtask

  task automatic test_reset_mid();
    start(16'h0123);
    if (bus.alu_execute !== 1'b1) begin errors++; $display("FAIL rm_exec got %b exp 1", bus.alu_execute); end checks++;
    rst = 1'b1; #1;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", bus.busy); end checks++;
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rm_wbv got %b exp 0", bus.wb_valid); end checks++;
    if (bus.alu_r2 !== 16'h0000) begin errors++; $display("FAIL rm_r2 got %h exp 0000", bus.alu_r2); end checks++;
    @(negedge clk);
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rm_wbv2 got %b exp 0", bus.wb_valid); end checks++;
    rst = 1'b0; #1;
    if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", bus.instr_ready); end checks++;
    if (bus.flags_q !== 4'h0) begin errors++; $display("FAIL rm_flags got %h exp 0", bus.flags_q); end checks++;
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = i[3:0]; #1;
      if (bus.dbg_data !== 16'h0) begin errors++; $display("FAIL rm_reg%0d got %h exp 0", i, bus.dbg_data); end checks++;
    end
    @(negedge clk);
    if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rm_wbv3 got %b exp 0", bus.wb_valid); end checks++;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.load_en     = 1'b0;
    bus.load_addr   = '0;
    bus.load_data   = '0;
    bus.dbg_addr    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_add();
    test_lsh();
    test_cmp();
    test_illegal();
    test_back_to_back();
    test_load();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
